text_loader: RTL and testbench

TEXT_LOADER -- requirements
Module: text_loader

---
 rtl/text_loader_if.sv | 25 ++
 rtl/text_loader.sv | 160 ++++++++++++++++
 tb/tb_text_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/text_loader_if.sv
// Byte-stream input and text-memory write port of the boot-time text loader.
// The loader takes the slave modport; the byte source and memory side take the master modport.
interface text_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic                  core_rst;
    logic                  done;
    logic                  error;

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, error
    );

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, core_rst, done, error
    );
endinterface

// File: rtl/text_loader.sv
// Loads a framed byte stream (A5 5A LEN payload) into text memory and then releases the core.
// Optional trailing XOR checksum byte is enabled by defining TEXT_LOADER_CHECKSUM_EN.
module text_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    text_loader_if.slave  bus
);
    localparam logic [31:0] CAP = 32'd1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_SYNC0,
        S_SYNC1,
        S_LEN,
        S_DATA,
`ifdef TEXT_LOADER_CHECKSUM_EN
        S_CHECK,
        S_ERROR,
`endif
        S_DONE
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_widx;
    logic [ADDR_WIDTH-1:0] r_last;
    logic [1:0]            r_lane;
    logic [23:0]           r_buf;
    logic                  r_in_ready;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  r_core_rst;
    logic                  r_done;
    logic                  w_xfer;
    logic [31:0]           w_len_n;
    logic [31:0]           w_len_cap;

    assign w_xfer    = bus.in_valid & r_in_ready;
    // LEN=0 encodes 256 words; the count is clipped to the memory capacity.
    assign w_len_n   = (bus.in_data == 8'h00) ? 32'd256 : {24'd0, bus.in_data};
    assign w_len_cap = (w_len_n > CAP) ? CAP : w_len_n;

`ifdef TEXT_LOADER_CHECKSUM_EN
    logic [7:0] r_chk;
    logic       r_error;
    assign bus.error = r_error;
`else
    assign bus.error = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_SYNC0;
            r_widx      <= '0;
            r_last      <= '0;
            r_lane      <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_core_rst  <= 1'b1;
            r_done      <= 1'b0;
`ifdef TEXT_LOADER_CHECKSUM_EN
            r_chk       <= '0;
            r_error     <= 1'b0;
`endif
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                S_SYNC0: begin
                    r_in_ready <= 1'b1;
                    if (w_xfer && bus.in_data == 8'hA5)
                        r_state <= S_SYNC1;
                end
                S_SYNC1: begin
                    r_in_ready <= 1'b1;
                    if (w_xfer) begin
                        if (bus.in_data == 8'h5A)
                            r_state <= S_LEN;
                        else if (bus.in_data != 8'hA5)
                            r_state <= S_SYNC0;
                    end
                end
                S_LEN: begin
                    r_in_ready <= 1'b1;
                    if (w_xfer) begin
                        r_last  <= ADDR_WIDTH'(w_len_cap - 32'd1);
                        r_widx  <= '0;
                        r_lane  <= '0;
`ifdef TEXT_LOADER_CHECKSUM_EN
                        r_chk   <= '0;
`endif
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    r_in_ready <= 1'b1;
                    if (w_xfer) begin
`ifdef TEXT_LOADER_CHECKSUM_EN
                        r_chk  <= r_chk ^ bus.in_data;
`endif
                        r_lane <= r_lane + 2'd1;
                        // Little-endian: bytes shift down so the first lands in [7:0].
                        if (r_lane != 2'd3) begin
                            r_buf <= {bus.in_data, r_buf[23:8]};
                        end else begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= r_widx;
                            r_mem_wdata <= {bus.in_data, r_buf};
                            if (r_widx == r_last) begin
`ifdef TEXT_LOADER_CHECKSUM_EN
                                r_state    <= S_CHECK;
`else
                                r_state    <= S_DONE;
                                r_in_ready <= 1'b0;
`endif
                            end else begin
                                r_widx <= r_widx + ADDR_WIDTH'(1);
                            end
                        end
                    end
                end
`ifdef TEXT_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    r_in_ready <= 1'b1;
                    if (w_xfer) begin
                        r_in_ready <= 1'b0;
                        if (bus.in_data == r_chk) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_core_rst <= 1'b0;
                        end else begin
                            r_state <= S_ERROR;
                            r_error <= 1'b1;
                        end
                    end
                end
                S_ERROR: begin
                    r_in_ready <= 1'b0;
                end
`endif
                // Release lags entry by a cycle so the final write pulse has completed.
                S_DONE: begin
                    r_in_ready <= 1'b0;
                    r_done     <= 1'b1;
                    r_core_rst <= 1'b0;
                end
                default: r_state <= S_SYNC0;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.core_rst  = r_core_rst;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_text_loader.sv
// Scoreboard bench for text_loader: stimulus pushes expected memory writes, a monitor pops and compares.
module tb_text_loader;
    localparam int AW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   passes = 0;
    int   total  = 0;
    int   cyc    = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        sb[$];
    logic [7:0] pl[$];

    text_loader_if #(.ADDR_WIDTH(AW)) bus ();

    text_loader #(.ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write_addr", {32'd0, 24'd0, bus.mem_addr}, 64'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("write_addr_data", {24'd0, bus.mem_addr, bus.mem_wdata}, {24'd0, e.addr, e.data});
            end
        end
    end

    task automatic do_reset();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_core_rst", bus.core_rst, 1);
        chk("rst_done",     bus.done, 0);
        chk("rst_error",    bus.error, 0);
        chk("rst_mem_we",   bus.mem_we, 0);
        chk("rst_mem_addr_wdata", {bus.mem_addr, bus.mem_wdata}, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
    endtask

    task automatic send(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) begin
                @(posedge clk); #1;
                return;
            end
        end
        chk("send_timeout", 1, 0);
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Sends a frame carrying the payload in pl and queues the words it should produce.
    task automatic load_frame(input logic [7:0] lenb, input bit gaps, input logic [7:0] chk_flip);
        logic [7:0] x;
        x = 8'h00;
        send(8'hA5); send(8'h5A); send(lenb);
        for (int i = 0; i < pl.size(); i++) begin
            if (gaps) idle($urandom_range(0, 2));
            send(pl[i]);
            x ^= pl[i];
            if (i % 4 == 3) begin
                wr_t e;
                e.addr = AW'(i / 4);
                e.data = {pl[i], pl[i-1], pl[i-2], pl[i-3]};
                sb.push_back(e);
            end
        end
`ifdef TEXT_LOADER_CHECKSUM_EN
        if (gaps) idle($urandom_range(0, 2));
        send(x ^ chk_flip);
`endif
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1;
        end
        chk({tag, "_done"}, bus.done, 1);
        chk({tag, "_core_rst"}, bus.core_rst, 0);
        chk({tag, "_error"}, bus.error, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 0);
        chk({tag, "_writes_drained"}, sb.size(), 0);
    endtask

    initial begin
        int c0;
        int nb;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        @(posedge clk); #1;
        do_reset();

        // Single-word frame.
        pl = {8'h13, 8'h00, 8'h00, 8'h00};
        load_frame(8'h01, 0, 8'h00);
        wait_done("single");

        // Junk before sync, back-to-back bytes at one per cycle.
        do_reset();
        pl = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        c0 = cyc;
        send(8'h00); send(8'hA5);
        load_frame(8'h02, 0, 8'h00);
`ifdef TEXT_LOADER_CHECKSUM_EN
        nb = 14;
`else
        nb = 13;
`endif
        chk("throughput_cycles", cyc - c0, nb);
        wait_done("junk");

        // Bytes offered after DONE are refused.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("after_done_in_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        chk("after_done_still_done", bus.done, 1);

        // Abort mid-word, then a clean frame reloads from address 0.
        do_reset();
        send(8'hA5); send(8'h5A); send(8'h01); send(8'hDE); send(8'hAD);
        do_reset();
        pl = {8'h01, 8'h02, 8'h03, 8'h04};
        load_frame(8'h01, 0, 8'h00);
        wait_done("abort");

`ifdef TEXT_LOADER_CHECKSUM_EN
        // Checksum off by one bit.
        do_reset();
        pl = {8'h13, 8'h00, 8'h00, 8'h00};
        load_frame(8'h01, 0, 8'h01);
        repeat (3) @(negedge clk);
        chk("badchk_error", bus.error, 1);
        chk("badchk_done", bus.done, 0);
        chk("badchk_core_rst", bus.core_rst, 1);
        chk("badchk_in_ready", bus.in_ready, 0);
        chk("badchk_writes_drained", sb.size(), 0);
`endif

        // LEN=0 means 256 words; last address 0xFF.
        do_reset();
        pl = {};
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = i[7:0];
            pl.push_back(b);
            pl.push_back(~b);
            pl.push_back(b ^ 8'h5A);
            pl.push_back(8'h3C);
        end
        load_frame(8'h00, 0, 8'h00);
        wait_done("len256");

        // Random gaps must give the same words as the gap-free case.
        do_reset();
        pl = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88,
              8'hC0, 8'hFF, 8'hEE, 8'h0D};
        load_frame(8'h03, 1, 8'h00);
        wait_done("gaps");
        idle(3);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
